// File: rtl/paralelo_serial_if.sv
// Byte handshake plus serial-line outputs of the PCI lane serializer.
// PS_TX_COUNT_EN adds the tx_count data-symbol counter to the bundle.
interface paralelo_serial_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic       sym_start;
    logic       active;
`ifdef PS_TX_COUNT_EN
    logic [7:0] tx_count;

    modport master (output data_in, valid_in,
                    input  ready_out, data_out, sym_start, active, tx_count);
    modport slave  (input  data_in, valid_in,
                    output ready_out, data_out, sym_start, active, tx_count);
`else
    modport master (output data_in, valid_in,
                    input  ready_out, data_out, sym_start, active);
    modport slave  (input  data_in, valid_in,
                    output ready_out, data_out, sym_start, active);
`endif
endinterface

// File: rtl/paralelo_serial.sv
// PCI lane TX serializer: 2-entry byte buffer, MSB-first shift-out, COM training.
// Optional macro PS_TX_COUNT_EN adds an 8-bit count of transmitted data symbols.
module paralelo_serial #(
    parameter int         MIN_BC   = 4,
    parameter logic [7:0] IDLE_SYM = 8'hBC
) (
    input  logic clk_32f,
    input  logic reset,
    paralelo_serial_if.slave bus
);

    localparam int CW = $clog2(MIN_BC + 2);

    typedef enum logic {TRAIN, ACTIVE} state_t;

    state_t          state;
    logic [7:0]      shift_reg;
    logic [2:0]      bit_cnt;
    logic [1:0][7:0] fifo;
    logic [1:0]      count;
    logic [CW-1:0]   com_cnt;
    logic            sym_start_q;
    logic            active_q;

    logic boundary, send_data, pop, push, wr_sel;

    assign boundary  = (bit_cnt == 3'd7);
    // The boundary that completes training already picks its symbol like ACTIVE
    assign send_data = boundary && (state == ACTIVE || com_cnt == CW'(MIN_BC));
    assign pop       = send_data && (count != 2'd0);
    assign push      = bus.valid_in && bus.ready_out;
    // Write slot sits behind whatever survives this edge's pop
    assign wr_sel    = count[0] & ~pop;

    assign bus.ready_out = reset && (count < 2'd2);
    assign bus.data_out  = shift_reg[7];
    assign bus.sym_start = sym_start_q;
    assign bus.active    = active_q;

`ifdef PS_TX_COUNT_EN
    logic [7:0] tx_count_q;
    assign bus.tx_count = tx_count_q;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset)   tx_count_q <= 8'd0;
        else if (pop) tx_count_q <= tx_count_q + 8'd1;
    end
`endif

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state       <= TRAIN;
            shift_reg   <= 8'd0;
            bit_cnt     <= 3'd7;
            fifo        <= '0;
            count       <= 2'd0;
            com_cnt     <= '0;
            sym_start_q <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            bit_cnt     <= bit_cnt + 3'd1;
            sym_start_q <= boundary;

            if (boundary) begin
                shift_reg <= pop ? fifo[0] : IDLE_SYM;
                if (state == TRAIN) begin
                    if (com_cnt == CW'(MIN_BC)) begin
                        state    <= ACTIVE;
                        active_q <= 1'b1;
                    end else begin
                        com_cnt <= com_cnt + 1'b1;
                    end
                end
            end else begin
                shift_reg <= {shift_reg[6:0], 1'b0};
            end

            if (pop)  fifo[0]      <= fifo[1];
            if (push) fifo[wr_sel] <= bus.data_in;

            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_paralelo_serial.sv
// Directed bench for paralelo_serial: training, single/back-to-back bytes,
// bytes held through TRAIN, mid-symbol reset and the optional tx_count.
module tb_paralelo_serial;

    logic clk_32f;
    logic reset;
    paralelo_serial_if bus();

    paralelo_serial #(.MIN_BC(4), .IDLE_SYM(8'hBC)) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    int n_chk  = 0;
    int n_pass = 0;
    int ph     = 7;

    // Line monitor: rebuilds symbols framed by sym_start, flags bad framing
    logic [7:0] sym_q[$];
    logic [7:0] cur;
    int         nbit    = 0;
    int         started = 0;
    int         start_err = 0;

    always @(negedge clk_32f) begin
        if (!reset) begin
            nbit    = 0;
            started = 0;
        end else begin
            if (bus.sym_start) begin
                if (started != 0 && nbit != 0) start_err++;
                cur     = {7'd0, bus.data_out};
                nbit    = 1;
                started = 1;
            end else if (started != 0) begin
                if (nbit == 0) start_err++;
                else begin
                    cur  = {cur[6:0], bus.data_out};
                    nbit++;
                end
            end
            if (nbit == 8) begin
                sym_q.push_back(cur);
                nbit = 0;
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_32f);
            #1;
            ph = (ph + 1) % 8;
        end
    endtask

    task automatic to_ph(input int p);
        while (ph != p) tick();
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.valid_in = 1'b1;
        bus.data_in  = 8'h77;
        tick(3);
        n_chk++;
        if (bus.data_out !== 1'b0) $display("FAIL reset_data_out got=%b exp=0", bus.data_out);
        else n_pass++;
        n_chk++;
        if (bus.sym_start !== 1'b0) $display("FAIL reset_sym_start got=%b exp=0", bus.sym_start);
        else n_pass++;
        n_chk++;
        if (bus.active !== 1'b0) $display("FAIL reset_active got=%b exp=0", bus.active);
        else n_pass++;
        n_chk++;
        if (bus.ready_out !== 1'b0) $display("FAIL reset_ready got=%b exp=0", bus.ready_out);
        else n_pass++;
        bus.valid_in = 1'b0;
        reset = 1'b1;
        ph    = 7;
    endtask

    task automatic test_train();
        sym_q.delete();
        tick();
        n_chk++;
        if ({bus.data_out, bus.sym_start} !== 2'b11)
            $display("FAIL train_first_bit got=%b exp=11", {bus.data_out, bus.sym_start});
        else n_pass++;
        tick(31);
        n_chk++;
        if (bus.active !== 1'b0) $display("FAIL train_active_early got=%b exp=0", bus.active);
        else n_pass++;
        tick();
        n_chk++;
        if ({bus.active, bus.sym_start} !== 2'b11)
            $display("FAIL train_active_rise got=%b exp=11", {bus.active, bus.sym_start});
        else n_pass++;
        tick(8);
        n_chk++;
        if (sym_q.size() != 5 || sym_q[0] !== 8'hBC || sym_q[1] !== 8'hBC || sym_q[2] !== 8'hBC
            || sym_q[3] !== 8'hBC || sym_q[4] !== 8'hBC)
            $display("FAIL train_com_run got=%p exp=5xBC", sym_q);
        else n_pass++;
        n_chk++;
        if (start_err != 0) $display("FAIL train_framing got=%0d exp=0", start_err);
        else n_pass++;
    endtask

    task automatic test_single();
        sym_q.delete();
        tick(3);
        bus.data_in  = 8'hA5;
        bus.valid_in = 1'b1;
        n_chk++;
        if (bus.ready_out !== 1'b1) $display("FAIL single_ready_pre got=%b exp=1", bus.ready_out);
        else n_pass++;
        tick();
        bus.valid_in = 1'b0;
        n_chk++;
        if (bus.ready_out !== 1'b1) $display("FAIL single_ready_post got=%b exp=1", bus.ready_out);
        else n_pass++;
        to_ph(0);
        tick(16);
        n_chk++;
        if (sym_q.size() != 3 || sym_q[0] !== 8'hBC || sym_q[1] !== 8'hA5 || sym_q[2] !== 8'hBC)
            $display("FAIL single_line got=%p exp=BC,A5,BC", sym_q);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        sym_q.delete();
        tick(2);
        bus.valid_in = 1'b1;
        bus.data_in  = 8'h11;
        tick();
        bus.data_in  = 8'h22;
        tick();
        n_chk++;
        if (bus.ready_out !== 1'b0) $display("FAIL b2b_full got=%b exp=0", bus.ready_out);
        else n_pass++;
        bus.data_in = 8'h33;
        tick(3);
        n_chk++;
        if (bus.ready_out !== 1'b0) $display("FAIL b2b_still_full got=%b exp=0", bus.ready_out);
        else n_pass++;
        tick();
        n_chk++;
        if (bus.ready_out !== 1'b1) $display("FAIL b2b_after_pop got=%b exp=1", bus.ready_out);
        else n_pass++;
        tick();
        bus.valid_in = 1'b0;
        n_chk++;
        if (bus.ready_out !== 1'b0) $display("FAIL b2b_33_taken got=%b exp=0", bus.ready_out);
        else n_pass++;
        tick(31);
        n_chk++;
        if (sym_q.size() != 5 || sym_q[0] !== 8'hBC || sym_q[1] !== 8'h11 || sym_q[2] !== 8'h22
            || sym_q[3] !== 8'h33 || sym_q[4] !== 8'hBC)
            $display("FAIL b2b_line got=%p exp=BC,11,22,33,BC", sym_q);
        else n_pass++;
    endtask

    task automatic test_train_hold();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        ph    = 7;
        sym_q.delete();
        tick(9);
        tick(2);
        bus.data_in  = 8'h5A;
        bus.valid_in = 1'b1;
        n_chk++;
        if (bus.ready_out !== 1'b1) $display("FAIL hold_ready got=%b exp=1", bus.ready_out);
        else n_pass++;
        tick();
        bus.valid_in = 1'b0;
        tick(21);
        n_chk++;
        if ({bus.active, bus.sym_start, bus.data_out} !== 3'b110)
            $display("FAIL hold_first_active got=%b exp=110", {bus.active, bus.sym_start, bus.data_out});
        else n_pass++;
        tick(16);
        n_chk++;
        if (sym_q.size() != 6 || sym_q[0] !== 8'hBC || sym_q[1] !== 8'hBC || sym_q[2] !== 8'hBC
            || sym_q[3] !== 8'hBC || sym_q[4] !== 8'h5A || sym_q[5] !== 8'hBC)
            $display("FAIL hold_line got=%p exp=4xBC,5A,BC", sym_q);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus.data_in  = 8'hF0;
        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        to_ph(0);
        bus.valid_in = 1'b1;
        bus.data_in  = 8'h81;
        tick();
        bus.data_in  = 8'h42;
        tick();
        bus.valid_in = 1'b0;
        n_chk++;
        if (bus.ready_out !== 1'b0) $display("FAIL mid_buf_full got=%b exp=0", bus.ready_out);
        else n_pass++;
        tick();
        n_chk++;
        if ({bus.data_out, bus.active} !== 2'b11)
            $display("FAIL mid_pre_reset got=%b exp=11", {bus.data_out, bus.active});
        else n_pass++;
        #1;
        reset = 1'b0;
        #1;
        n_chk++;
        if ({bus.data_out, bus.active, bus.ready_out, bus.sym_start} !== 4'b0000)
            $display("FAIL mid_async_reset got=%b exp=0000",
                     {bus.data_out, bus.active, bus.ready_out, bus.sym_start});
        else n_pass++;
        tick();
        reset = 1'b1;
        ph    = 7;
        sym_q.delete();
        tick(33);
        n_chk++;
        if (bus.active !== 1'b1) $display("FAIL mid_retrain_active got=%b exp=1", bus.active);
        else n_pass++;
        tick(16);
        n_chk++;
        if (sym_q.size() != 6 || sym_q[0] !== 8'hBC || sym_q[1] !== 8'hBC || sym_q[2] !== 8'hBC
            || sym_q[3] !== 8'hBC || sym_q[4] !== 8'hBC || sym_q[5] !== 8'hBC)
            $display("FAIL mid_flushed got=%p exp=6xBC", sym_q);
        else n_pass++;
        n_chk++;
        if (start_err != 0) $display("FAIL mid_framing got=%0d exp=0", start_err);
        else n_pass++;
    endtask

`ifdef PS_TX_COUNT_EN
    task automatic test_tx_count();
        int guard;
        n_chk++;
        if (bus.tx_count !== 8'd0) $display("FAIL txc_after_reset got=%0d exp=0", bus.tx_count);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick(3);
            bus.data_in  = 8'hC0 + 8'(k);
            bus.valid_in = 1'b1;
            tick();
            bus.valid_in = 1'b0;
            to_ph(0);
            tick(8);
        end
        n_chk++;
        if (bus.tx_count !== 8'd3) $display("FAIL txc_three got=%0d exp=3", bus.tx_count);
        else n_pass++;
        guard = 0;
        for (int k = 0; k < 256; k++) begin
            bus.data_in  = 8'(k);
            bus.valid_in = 1'b1;
            while (bus.ready_out !== 1'b1 && guard < 5000) begin
                tick();
                guard++;
            end
            tick();
        end
        bus.valid_in = 1'b0;
        n_chk++;
        if (guard >= 5000) $display("FAIL txc_timeout got=%0d exp<5000", guard);
        else n_pass++;
        tick(32);
        n_chk++;
        if (bus.tx_count !== 8'd3) $display("FAIL txc_wrap got=%0d exp=3", bus.tx_count);
        else n_pass++;
    endtask
`endif

    initial begin
        bus.data_in  = 8'h00;
        bus.valid_in = 1'b0;
        reset        = 1'b0;
        test_reset();
        test_train();
        test_single();
        test_back_to_back();
        test_train_hold();
        test_reset_mid();
`ifdef PS_TX_COUNT_EN
        test_tx_count();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/paralelo_serial.md
Name: paralelo_serial

Overview:
- Transmit-side serializer of the PCI physical-layer lane.
- Sits directly upstream of the lane's serial-to-parallel receiver.
- Accepts bytes over a valid/ready handshake into a 2-entry buffer and shifts them out MSB-first at one bit per clk_32f cycle.
- Sends 0xBC (COM) idle symbols when it has no data. Sends a mandatory run of COM symbols after reset so the receiver can align and go active.

Parameters:
- MIN_BC, 4: number of complete COM symbols sent after reset before data may be sent.
- IDLE_SYM, 8'hBC: idle/training symbol value.

Ports:
- clk_32f, input, 1: bit clock. All logic on posedge.
- reset, input, 1: asynchronous, active-low reset. One clock domain only (clk_32f).
- data_in, input, 8: parallel byte to transmit.
- valid_in, input, 1: data_in valid.
- ready_out, output, 1: buffer can accept a byte. A transfer occurs on a posedge with valid_in && ready_out.
- data_out, output, 1: serial line, MSB of the current symbol first.
- sym_start, output, 1: high during the cycle the first bit (bit 7) of a symbol is on data_out.
- active, output, 1: training complete; data symbols may be sent.

Behaviour:
- Reset values (asynchronous): data_out=0, sym_start=0, active=0, ready_out=0.
  - Internal state at reset: shift register=0, bit counter=7, buffer empty, COM counter=0, state=TRAIN.
- ready_out = reset && (buffer count < 2). It is combinational from registered count and is never high while reset=0.
- data_out = shift_reg[7], a direct register output.
- Bit counter (3 bits) increments every cycle and wraps 7->0.
- Symbol boundary = the posedge where bit counter==7.
  - At the boundary, shift_reg loads the next symbol. Otherwise shift_reg shifts left, filling 0.
  - The first boundary is the first posedge after reset deasserts.
- sym_start is registered: 1 on the cycle after a boundary load, 0 otherwise.
- Buffer: 2-entry FIFO, in-order.
  - A push occurs on a posedge with valid_in && ready_out.
  - A pop occurs only at a boundary, in ACTIVE state, with pre-edge count>0.
  - Push and pop on the same edge are both allowed; count is unchanged. Data is written behind the popped entry.
  - Push into an empty buffer on a boundary edge is not visible to that edge's pop. That boundary sends IDLE_SYM and the byte goes at the next boundary.
  - Overflow is impossible because ready_out gates it. valid_in while ready_out=0 is ignored, with no data change.
- State machine:
  - TRAIN:
    - At each boundary, load IDLE_SYM and increment the COM counter (saturates at MIN_BC).
    - At the boundary where the counter already equals MIN_BC, go to ACTIVE and set active=1 on that edge. That symbol is chosen by ACTIVE rules.
    - Bytes may be pushed in TRAIN (up to 2). They are held, not sent.
  - ACTIVE:
    - At each boundary, if the buffer is non-empty, pop and load the head byte. Otherwise load IDLE_SYM.
    - Remains ACTIVE until reset.
- Timing:
  - active rises on the posedge 8*MIN_BC cycles after the first boundary (cycle 33 after reset release for MIN_BC=4).
  - Byte-to-line latency with an empty buffer in ACTIVE: bit 7 appears 1-8 cycles after the push edge, at the next boundary, or the one after if the push lands on a boundary edge.
- A user byte equal to IDLE_SYM is sent unmodified. The protocol reserves it, so the receiver treats it as idle.
- Reset asserted mid-symbol: the partial symbol is dropped, the buffer is flushed, active=0, and training restarts from 0 COMs.

Optional Feature:
- Macro PS_TX_COUNT_EN.
- Defined: adds output tx_count [7:0], reset 0.
  - Increments on every boundary that loads a popped data byte; never on idle symbols.
  - Wraps 255->0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Release reset, valid_in=0:
  - data_out repeats 1,0,1,1,1,1,0,0 from the cycle after the first posedge.
  - sym_start is high every 8th cycle.
  - active=1 after exactly 32 bits of COM, then COM continues.
- ACTIVE, push 0xA5 mid-symbol: next symbol on data_out is 1,0,1,0,0,1,0,1, then COM resumes. ready_out stays 1.
- ACTIVE, hold valid_in with 0x11, 0x22, 0x33 back-to-back:
  - 0x11 and 0x22 are accepted, then ready_out=0.
  - 0x33 is accepted on the edge after the first pop.
  - Line order is 0x11, 0x22, 0x33 in consecutive symbols.
- Push 0x5A during TRAIN (2nd COM): 0x5A is held; after 4 COMs the first ACTIVE symbol is 0x5A.
- Assert reset in the middle of a 0xF0 symbol with the buffer full:
  - data_out=0, active=0 and ready_out=0 immediately, without waiting for a clock edge.
  - After release, 4 COMs are sent, then idle; buffered bytes are never sent.
- With PS_TX_COUNT_EN defined, send 3 data bytes amid idles: tx_count=3. After 256 more data bytes, tx_count=3 again (wrap).
